jtframe_upload_reader: RTL and testbench

- Serves HPS upload requests by reading game memory (NVRAM, hiscore and dump regions) back out of SDRAM, byte by byte.
- Reverse direction of the ioctl download to prog write path.
- Sits between the hps_io ioctl upload port and the board SDRAM controller's prog read channel.
- Holds a one-word (32-bit) cache, so sequential bytes cost one SDRAM read per four bytes.

---
 rtl/jtframe_upload_pkg.sv | 15 +
 rtl/jtframe_upload_reader.sv | 186 ++++++++++++++++++
 tb/tb_jtframe_upload_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_upload_pkg.sv
// Shared types and helpers for the upload reader.
//   state_t  : reader FSM states
//   TAGW     : cache tag width (byte address bits [21:2])
//   lane_sel : picks one byte out of a 32-bit little-endian SDRAM word pair
package jtframe_upload_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    localparam int TAGW = 20;

    function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/jtframe_upload_reader.sv
// Serves HPS upload requests by reading game memory back out of SDRAM one
// byte at a time, through a one-word (32-bit) cache so that sequential
// bytes cost one SDRAM read per four bytes.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   ioctl_upload/rd/addr          hps_io upload request side
//   ioctl_din, ioctl_wait         returned byte, hold-off while fetching
//   prog_addr, prog_rd, sdram_ack SDRAM prog read request (16-bit word addr)
//   data_rdy, data_read           SDRAM read data (two 16-bit words)
//   busy                          FSM not in IDLE
//   err                           sticky: timeout or request while busy;
//                                 cleared when an upload session starts
module jtframe_upload_reader
    import jtframe_upload_pkg::*;
#(
    parameter logic [21:0] BASE    = 22'h0,
    parameter logic [21:0] SIZE    = 22'h400,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [21:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [21:0] prog_addr,
    output logic        prog_rd,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [21:0]       paddr_q, paddr_d;
    logic              prd_q, prd_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       cache_q, cache_d;
    logic [7:0]        timer_q, timer_d;
    logic              upload_q;

    logic [21:0]       ba;
    logic              hit, upl_rise, upl_fall, tmo_hit, abort;

    assign ba       = BASE + ioctl_addr;
    assign hit      = valid_q && (tag_q == ba[21:2]);
    assign upl_rise = ioctl_upload && !upload_q;
    assign upl_fall = !ioctl_upload && upload_q;
    assign tmo_hit  = (timer_q == TMO);

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        paddr_d = paddr_q;
        prd_d   = prd_q;
        err_d   = err_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        lane_d  = lane_q;
        cache_d = cache_q;
        timer_d = timer_q;
        abort   = 1'b0;

        if (upl_rise) err_d = 1'b0;
        // Any request outside IDLE (including the data_rdy cycle) is dropped.
        if (state_q != IDLE && ioctl_upload && ioctl_rd) err_d = 1'b1;
        if (upl_fall) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ioctl_upload && ioctl_rd) begin
                    if (ioctl_addr >= SIZE) begin
                        din_d = 8'hFF;
                    end else if (hit) begin
                        din_d = lane_sel(cache_q, ba[1:0]);
                    end else begin
                        wait_d  = 1'b1;
                        prd_d   = 1'b1;
                        paddr_d = {ba[21:2], 1'b0};
                        tag_d   = ba[21:2];
                        lane_d  = ba[1:0];
                        // tag is being replaced, old data must not hit
                        valid_d = 1'b0;
                        timer_d = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (upl_fall) begin
                    prd_d   = 1'b0;
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end else if (sdram_ack) begin
                    prd_d   = 1'b0;
                    timer_d = 8'd0;
                    state_d = WAIT;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT: begin
                if (upl_fall) begin
                    // session ended under us: data is discarded when it shows up
                    wait_d  = 1'b0;
                    state_d = data_rdy ? IDLE : DRAIN;
                end else if (data_rdy) begin
                    cache_d = data_read;
                    valid_d = 1'b1;
                    din_d   = lane_sel(data_read, lane_q);
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DRAIN: begin
                if (data_rdy || tmo_hit) state_d = IDLE;
                else                     timer_d = timer_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            din_d   = 8'hFF;
            err_d   = 1'b1;
            valid_d = 1'b0;
            wait_d  = 1'b0;
            prd_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            din_q    <= 8'hFF;
            wait_q   <= 1'b0;
            paddr_q  <= 22'd0;
            prd_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            lane_q   <= 2'd0;
            cache_q  <= 32'd0;
            timer_q  <= 8'd0;
            upload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            paddr_q  <= paddr_d;
            prd_q    <= prd_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            lane_q   <= lane_d;
            cache_q  <= cache_d;
            timer_q  <= timer_d;
            upload_q <= ioctl_upload;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign prog_addr  = paddr_q;
    assign prog_rd    = prd_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_jtframe_upload_reader.sv
module tb_jtframe_upload_reader;

    localparam logic [21:0] BASE = 22'h100;
    localparam logic [21:0] SIZE = 22'h400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_upload, ioctl_rd;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [21:0] prog_addr;
    logic        prog_rd, sdram_ack, data_rdy, busy, err;
    logic [31:0] data_read;

    int n_pass = 0;
    int n_chk  = 0;
    int n_req  = 0;
    int cyc;
    logic [7:0] din_before;

    // responder controls
    logic ack_en    = 1'b1;
    logic hold_data = 1'b0;
    int   data_dly  = 1;

    always #5 clk = ~clk;

    jtframe_upload_reader #(.BASE(BASE), .SIZE(SIZE), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .prog_addr(prog_addr), .prog_rd(prog_rd), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read),
        .busy(busy), .err(err)
    );

    // SDRAM content, indexed by 16-bit word address
    function automatic logic [31:0] mem(input logic [21:0] a);
        case (a)
            22'h080: return 32'hDDCCBBAA;
            22'h082: return 32'h44332211;
            default: return 32'h5A6B7C8D;
        endcase
    endfunction

    // SDRAM responder: ack one cycle after the request, data data_dly after ack
    initial begin : responder
        logic [21:0] ra;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = 32'd0;
        forever begin
            @(negedge clk);
            if (prog_rd === 1'b1 && ack_en && !sdram_ack) begin
                n_req++;
                ra = prog_addr;
                @(negedge clk); sdram_ack = 1'b1;
                @(negedge clk); sdram_ack = 1'b0;
                if (!hold_data) begin
                    repeat (data_dly - 1) @(negedge clk);
                    data_rdy  = 1'b1;
                    data_read = mem(ra);
                    @(negedge clk); data_rdy = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input logic [21:0] a);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk);
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output int c);
        c = 0;
        while (ioctl_wait !== 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic upload_toggle();
        @(negedge clk); ioctl_upload = 1'b0;
        @(negedge clk); ioctl_upload = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 22'd0;

        // reset state
        #12;
        chk("rst_din",   32'(ioctl_din), 32'hFF);
        chk("rst_wait",  32'(ioctl_wait), 0);
        chk("rst_prd",   32'(prog_rd), 0);
        chk("rst_paddr", 32'(prog_addr), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_err",   32'(err), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); ioctl_upload = 1'b1;
        @(negedge clk);

        // first byte misses: byte 0x100 -> word address 0x080
        rd(22'd0);
        chk("miss0_wait",  32'(ioctl_wait), 1);
        chk("miss0_prd",   32'(prog_rd), 1);
        chk("miss0_paddr", 32'(prog_addr), 32'h080);
        chk("miss0_busy",  32'(busy), 1);
        wait_idle(50, cyc);
        chk("miss0_bound", 32'(cyc < 50), 1);
        chk("byte0", 32'(ioctl_din), 32'hAA);

        // remaining three bytes hit the cache
        rd(22'd1);
        chk("hit1_wait", 32'(ioctl_wait), 0);
        chk("byte1", 32'(ioctl_din), 32'hBB);
        rd(22'd2);
        chk("byte2", 32'(ioctl_din), 32'hCC);
        rd(22'd3);
        chk("hit3_wait", 32'(ioctl_wait), 0);
        chk("byte3", 32'(ioctl_din), 32'hDD);
        chk("one_req", 32'(n_req), 1);

        // next word
        rd(22'd4);
        chk("miss4_wait",  32'(ioctl_wait), 1);
        chk("miss4_paddr", 32'(prog_addr), 32'h082);
        wait_idle(50, cyc);
        chk("miss4_bound", 32'(cyc < 50), 1);
        chk("byte4", 32'(ioctl_din), 32'h11);
        chk("two_req", 32'(n_req), 2);

        // out of range
        rd(SIZE);
        chk("oor_din",  32'(ioctl_din), 32'hFF);
        chk("oor_wait", 32'(ioctl_wait), 0);
        chk("oor_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("oor_noreq", 32'(n_req), 2);

        // data withheld -> timeout after 255 cycles in WAIT
        hold_data = 1'b1;
        rd(22'd8);
        wait_idle(400, cyc);
        chk("tmo_window", 32'(cyc >= 255 && cyc <= 262), 1);
        chk("tmo_din",  32'(ioctl_din), 32'hFF);
        chk("tmo_err",  32'(err), 1);
        chk("tmo_busy", 32'(busy), 0);
        hold_data = 1'b0;
        rd(22'd9);
        chk("retry_prd", 32'(prog_rd), 1);
        wait_idle(50, cyc);
        chk("retry_byte", 32'(ioctl_din), 32'h7C);
        chk("retry_req", 32'(n_req), 4);
        chk("err_sticky", 32'(err), 1);

        // new session clears err; request while busy sets it and is ignored
        upload_toggle();
        chk("err_clear", 32'(err), 0);
        rd(22'd12);
        rd(22'd13);
        wait_idle(50, cyc);
        chk("busy_rd_err", 32'(err), 1);
        chk("busy_rd_lane", 32'(ioctl_din), 32'h8D);

        // upload drops while in WAIT, data arrives ~10 cycles later
        data_dly = 10;
        rd(22'd0);
        cyc = 0;
        while (prog_rd !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
        din_before = ioctl_din;
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("drain_wait", 32'(ioctl_wait), 0);
        chk("drain_busy", 32'(busy), 1);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("drain_bound", 32'(cyc < 40), 1);
        chk("drain_din", 32'(ioctl_din), 32'(din_before));
        data_dly = 1;
        @(negedge clk); ioctl_upload = 1'b1;
        rd(22'd0);
        chk("post_drain_miss", 32'(prog_rd), 1);
        wait_idle(50, cyc);
        chk("post_drain_byte", 32'(ioctl_din), 32'hAA);

        // async reset while a request sits in REQ
        ack_en = 1'b0;
        rd(22'd4);
        rd(22'd5);
        chk("req_prd", 32'(prog_rd), 1);
        chk("req_err", 32'(err), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_prd",  32'(prog_rd), 0);
        chk("arst_wait", 32'(ioctl_wait), 0);
        chk("arst_err",  32'(err), 0);
        chk("arst_din",  32'(ioctl_din), 32'hFF);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;
        ack_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
